// File: rtl/ex_div_ctrl.sv
// rtl/ex_div_ctrl.sv - radix-2 restoring divide sequencer for the execution stage
// Optional feature macro: DIV_EARLY_TERM_EN (skip the step sequence when |dividend| < |divisor|)
module ex_div_ctrl #(
  parameter int DIV_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [DIV_W-1:0]   opdata1_i,
  input  logic [DIV_W-1:0]   opdata2_i,
  output logic [2*DIV_W-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o,
  output logic               busy_o
);

  localparam int CNT_W = $clog2(DIV_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_W - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB,
  // so after the last step this register holds the raw quotient.
  logic [DIV_W-1:0]   dvd_q, dvd_d;
  logic [DIV_W-1:0]   dvs_q, dvs_d;
  logic [DIV_W-1:0]   rem_q, rem_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic [2*DIV_W-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic               accept;
  logic               acc_neg_q, acc_neg_r;
  logic [DIV_W-1:0]   op1_mag, op2_mag;
  logic [DIV_W:0]     partial, trial;
  logic [DIV_W-1:0]   step_rem, step_quo;

  // Apply the sign of the original operands to the magnitude result, {rem, quo}.
  function automatic logic [2*DIV_W-1:0] fixup(input logic [DIV_W-1:0] q,
                                               input logic [DIV_W-1:0] r,
                                               input logic             nq,
                                               input logic             nr);
    logic [DIV_W-1:0] fq;
    logic [DIV_W-1:0] fr;
    fq = nq ? -q : q;
    fr = nr ? -r : r;
    return {fr, fq};
  endfunction

  // Operand magnitudes and result signs captured on the accept cycle.
  always_comb begin
    accept    = start_i & ~annul_i;
    op1_mag   = (signed_div_i && opdata1_i[DIV_W-1]) ? -opdata1_i : opdata1_i;
    op2_mag   = (signed_div_i && opdata2_i[DIV_W-1]) ? -opdata2_i : opdata2_i;
    acc_neg_q = signed_div_i & (opdata1_i[DIV_W-1] ^ opdata2_i[DIV_W-1]);
    acc_neg_r = signed_div_i & opdata1_i[DIV_W-1];
  end

  // One restoring step: shift in the next dividend bit and try a subtract.
  always_comb begin
    partial  = {rem_q, dvd_q[DIV_W-1]};
    trial    = partial - {1'b0, dvs_q};
    step_quo = {dvd_q[DIV_W-2:0], ~trial[DIV_W]};
    step_rem = trial[DIV_W] ? partial[DIV_W-1:0] : trial[DIV_W-1:0];
  end

  // Sequencer next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          dvd_d   = op1_mag;
          dvs_d   = op2_mag;
          rem_d   = '0;
          cnt_d   = '0;
          neg_q_d = acc_neg_q;
          neg_r_d = acc_neg_r;
          if (op2_mag == '0) begin
            state_d = S_DIVZERO;
`ifdef DIV_EARLY_TERM_EN
          end else if (op1_mag < op2_mag) begin
            state_d  = S_END;
            result_d = fixup('0, op1_mag, acc_neg_q, acc_neg_r);
`endif
          end else begin
            state_d = S_ON;
          end
        end
      end
      S_DIVZERO: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_END;
          result_d = fixup('1, dvd_q, neg_q_q, neg_r_q);
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          rem_d = step_rem;
          dvd_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state_d  = S_END;
            result_d = fixup(step_quo, step_rem, neg_q_q, neg_r_q);
          end
        end
      end
      S_END: begin
        if (annul_i || !start_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_END);
  end

  // State, datapath and registered result with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign busy_o     = (state_q != S_IDLE);
  assign stallreq_o = ~annul_i & (((state_q == S_IDLE) & start_i) |
                                  (state_q == S_DIVZERO) | (state_q == S_ON));

endmodule
